// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; collects in-order data-RAM read responses, aligns/extends load data, drives MEM->WB and forwards to ID
// Ports:
//    clk, rst_b                     clock, asynchronous active-low reset
//    mem_pipe_*  (in, ready/flush out) EX->MEM pipeline register handshake and payload
//    wb_pipe_*   (out, ready/flush in) MEM->WB pipeline register handshake and payload
//    mem_rd_*, mem_load_pending     forwarding and load-use stall information for ID
//    dram_data_ok, dram_rdata       in-order single-cycle read responses
// Optional feature: define MEM_LOAD_MISALIGN_EN to add wb_pipe_exc_load_mis; a misaligned
// load then completes at once with zero data.
module mem_stage #(
   parameter int XLEN         = 32,
   parameter int REG_AW       = 5,
   parameter int MEM_OP_WIDTH = 3,
   parameter int DROP_CNT_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst_b,
   output logic                    mem_pipe_ready,
   output logic                    mem_pipe_flush,
   input  logic                    mem_pipe_valid,
   input  logic [XLEN-1:0]         mem_pipe_pc,
   input  logic [XLEN-1:0]         mem_pipe_instruction,
   input  logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
   input  logic                    mem_pipe_mem_read,
   input  logic [1:0]              mem_pipe_mem_byte_addr,
   input  logic                    mem_pipe_unsign,
   input  logic                    mem_pipe_rd_write,
   input  logic [REG_AW-1:0]       mem_pipe_rd_addr,
   input  logic [XLEN-1:0]         mem_pipe_alu_result,
   input  logic                    wb_pipe_ready,
   input  logic                    wb_pipe_flush,
   output logic                    wb_pipe_valid,
   output logic [XLEN-1:0]         wb_pipe_pc,
   output logic [XLEN-1:0]         wb_pipe_instruction,
   output logic                    wb_pipe_rd_write,
   output logic [REG_AW-1:0]       wb_pipe_rd_addr,
   output logic [XLEN-1:0]         wb_pipe_rd_wdata,
`ifdef MEM_LOAD_MISALIGN_EN
   output logic                    wb_pipe_exc_load_mis,
`endif
   output logic                    mem_rd_write,
   output logic [REG_AW-1:0]       mem_rd_addr,
   output logic [XLEN-1:0]         mem_rd_wdata,
   output logic                    mem_load_pending,
   input  logic                    dram_data_ok,
   input  logic [XLEN-1:0]         dram_rdata
);
   localparam int OP_BYTE = 0;
   localparam int OP_HALF = 1;
   localparam int OP_WORD = 2;
   typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
   state_t                state_q, state_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0]       rbuf_q, rbuf_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [XLEN-1:0]       wb_pc_q, wb_pc_d;
   logic [XLEN-1:0]       wb_instr_q, wb_instr_d;
   logic                  wb_rd_write_q, wb_rd_write_d;
   logic [REG_AW-1:0]     wb_rd_addr_q, wb_rd_addr_d;
   logic [XLEN-1:0]       wb_rd_wdata_q, wb_rd_wdata_d;
   logic                  mis_q, mis_d;
   logic                  mem_valid, resp_hit, mis, mem_done, inc, dec;
   logic [XLEN-1:0]       src, ld_data, final_data;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   always_comb begin
      mem_valid  = mem_pipe_valid & ~wb_pipe_flush;
      resp_hit   = (state_q == WAIT) & dram_data_ok & (drop_cnt_q == '0);
`ifdef MEM_LOAD_MISALIGN_EN
      mis        = mem_pipe_mem_read & ((mem_pipe_mem_opcode[OP_HALF] & mem_pipe_mem_byte_addr[0]) |
                                        (mem_pipe_mem_opcode[OP_WORD] & |mem_pipe_mem_byte_addr));
`else
      mis        = 1'b0;
`endif
      mem_done   = ~mem_pipe_mem_read | (state_q == DATA) | resp_hit | mis;
      // A response held back by WB stalls lives in rbuf until WB accepts it.
      src        = (state_q == DATA) ? rbuf_q : dram_rdata;
      ld_byte    = src[{mem_pipe_mem_byte_addr, 3'b000} +: 8];
      ld_half    = mem_pipe_mem_byte_addr[1] ? src[31:16] : src[15:0];
      ld_data    = mem_pipe_mem_opcode[OP_BYTE] ? {{(XLEN-8){~mem_pipe_unsign & ld_byte[7]}}, ld_byte} :
                   mem_pipe_mem_opcode[OP_HALF] ? {{(XLEN-16){~mem_pipe_unsign & ld_half[15]}}, ld_half} :
                   mem_pipe_mem_opcode[OP_WORD] ? src : '0;
      final_data = ~mem_pipe_mem_read ? mem_pipe_alu_result : mis ? '0 : ld_data;
      state_d    = wb_pipe_flush ? IDLE :
                   (state_q == IDLE) ? ((mem_valid & mem_pipe_mem_read & ~mem_done) ? WAIT : IDLE) :
                   (state_q == WAIT) ? (resp_hit ? (wb_pipe_ready ? IDLE : DATA) : WAIT) :
                   (wb_pipe_ready ? IDLE : DATA);
      rbuf_d     = (resp_hit & ~wb_pipe_ready) ? dram_rdata : rbuf_q;
      // Each load flushed while its response is still outstanding owes one response to discard.
      inc        = wb_pipe_flush & (state_q == WAIT) & ~resp_hit;
      dec        = dram_data_ok & (drop_cnt_q != '0);
      drop_cnt_d = (inc & ~dec & ~&drop_cnt_q) ? drop_cnt_q + DROP_CNT_W'(1) :
                   (dec & ~inc) ? drop_cnt_q - DROP_CNT_W'(1) : drop_cnt_q;
      wb_valid_d    = wb_pipe_ready ? mem_valid & mem_done : wb_valid_q;
      wb_pc_d       = wb_pipe_ready ? mem_pipe_pc : wb_pc_q;
      wb_instr_d    = wb_pipe_ready ? mem_pipe_instruction : wb_instr_q;
      wb_rd_write_d = wb_pipe_ready ? mem_pipe_rd_write : wb_rd_write_q;
      wb_rd_addr_d  = wb_pipe_ready ? mem_pipe_rd_addr : wb_rd_addr_q;
      wb_rd_wdata_d = wb_pipe_ready ? final_data : wb_rd_wdata_q;
      mis_d         = wb_pipe_ready ? mis : mis_q;
   end
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= IDLE;
         drop_cnt_q    <= '0;
         rbuf_q        <= '0;
         wb_valid_q    <= 1'b0;
         wb_pc_q       <= '0;
         wb_instr_q    <= '0;
         wb_rd_write_q <= 1'b0;
         wb_rd_addr_q  <= '0;
         wb_rd_wdata_q <= '0;
         mis_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         drop_cnt_q    <= drop_cnt_d;
         rbuf_q        <= rbuf_d;
         wb_valid_q    <= wb_valid_d;
         wb_pc_q       <= wb_pc_d;
         wb_instr_q    <= wb_instr_d;
         wb_rd_write_q <= wb_rd_write_d;
         wb_rd_addr_q  <= wb_rd_addr_d;
         wb_rd_wdata_q <= wb_rd_wdata_d;
         mis_q         <= mis_d;
      end
   end
   assign mem_pipe_ready      = ~mem_valid | (mem_done & wb_pipe_ready);
   assign mem_pipe_flush      = wb_pipe_flush;
   assign wb_pipe_valid       = wb_valid_q;
   assign wb_pipe_pc          = wb_pc_q;
   assign wb_pipe_instruction = wb_instr_q;
   assign wb_pipe_rd_write    = wb_rd_write_q;
   assign wb_pipe_rd_addr     = wb_rd_addr_q;
   assign wb_pipe_rd_wdata    = wb_rd_wdata_q;
`ifdef MEM_LOAD_MISALIGN_EN
   assign wb_pipe_exc_load_mis = mis_q;
`endif
   assign mem_rd_write        = mem_pipe_valid & mem_pipe_rd_write & mem_done;
   assign mem_rd_addr         = mem_pipe_rd_addr;
   assign mem_rd_wdata        = final_data;
   assign mem_load_pending    = mem_pipe_valid & mem_pipe_mem_read & ~mem_done;
endmodule
